// File: rtl/crc8_pkg.sv
// -----------------------------------------------------------------------------
// crc8_pkg
// Shared CRC-8 definitions for the serial CRC-8 generator and checker.
//   CRC8_POLY    : generator polynomial D8+D2+D+1 (implicit D8 term dropped)
//   CRC8_INIT    : register seed at start of every frame
//   crc8_state_e : checker frame FSM states
//   crc8_next()  : one MSB-first serial CRC step, no final XOR
// -----------------------------------------------------------------------------
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2
  } crc8_state_e;

  // Shift one data bit into the CRC; the polynomial is folded in when the
  // bit leaving the top of the register differs from the incoming bit.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
    logic fb;
    fb        = crc[7] ^ din;
    crc8_next = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial_lfsr.sv
// -----------------------------------------------------------------------------
// crc8_serial_lfsr
// Bit-serial CRC-8 register. On an enabled cycle it absorbs bit_in; with seed
// also high the step starts from CRC8_INIT instead of the held value, so the
// first bit of a frame is consumed on the same cycle the register restarts.
//   clk, rst_n : clock, asynchronous active-low reset (state -> CRC8_INIT)
//   seed       : restart from CRC8_INIT on this enabled step
//   enable     : absorb bit_in this cycle; otherwise hold
//   bit_in     : serial data bit, MSB first
//   crc        : current register contents
// -----------------------------------------------------------------------------
module crc8_serial_lfsr
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed,
  input  logic       enable,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_r;

  // CRC register: seed/advance on enabled cycles, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= CRC8_INIT;
    end else if (enable) begin
      crc_r <= crc8_next(seed ? CRC8_INIT : crc_r, bit_in);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/crc8_serial_check.sv
// -----------------------------------------------------------------------------
// crc8_serial_check
// Serial CRC-8 receive checker. Takes a frame of PAYLOAD_BYTES*8 payload bits
// followed by 8 CRC bits (MSB first), emits the payload as bytes, recomputes
// the CRC and flags pass/fail per frame. A new sof mid-frame aborts the frame.
//   PAYLOAD_BYTES : payload bytes per frame (1..64)
//   clk, rst_n    : clock, asynchronous active-low reset
//   bit_in        : serial bit, sampled when bit_valid is high
//   bit_valid     : qualifies bit_in; gaps allowed
//   sof           : start of frame, with the first payload bit
//   byte_out      : last assembled payload byte (first bit received in [7])
//   byte_valid    : pulse, byte_out updated
//   frame_done    : pulse after the last CRC bit
//   crc_ok/crc_err: pulse with frame_done, received CRC matched / mismatched
//   abort         : pulse, frame truncated by a new sof
//   crc_calc      : computed CRC of the last completed frame, held
//   err_cnt       : saturating count of crc_err and abort events
//                   (present only when CRC8_CHK_ERRCNT_EN is defined)
// -----------------------------------------------------------------------------
module crc8_serial_check
  import crc8_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        sof,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        abort,
  output logic [7:0]  crc_calc
`ifdef CRC8_CHK_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int PAY_BITS = PAYLOAD_BYTES * 8;
  localparam int CNT_W    = $clog2(PAY_BITS + 8);
  localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(PAY_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(PAY_BITS + 7);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  crc8_state_e      state_r, state_nxt_s;
  // cnt_r holds the in-frame index of the most recently sampled bit.
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, idx_s;
  // Only 7 bits of the received CRC (and of a payload byte) need storing:
  // the final bit is combined live on the cycle it arrives.
  logic [6:0]       cap_r, cap_nxt_s;
  logic [6:0]       byte_sr_r, byte_sr_nxt_s;
  logic [7:0]       crc_s, cap_fin_s;
  logic             start_s, crc_last_s, crc_match_s;
  logic             lfsr_en_s, lfsr_seed_s;
  logic             byte_load_s, done_s, abort_s;

  assign start_s     = sof & bit_valid;
  assign idx_s       = cnt_r + CNT_ONE;
  assign crc_last_s  = (state_r == CRC) && bit_valid && (idx_s == LAST_CRC);
  assign cap_fin_s   = {cap_r, bit_in};
  assign crc_match_s = (cap_fin_s == crc_s);

  crc8_serial_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .seed   (lfsr_seed_s),
    .enable (lfsr_en_s),
    .bit_in (bit_in),
    .crc    (crc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath control. A sampled sof always restarts a frame;
  // it aborts the old one unless that bit also completes the old CRC field,
  // in which case the old frame still finishes normally.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    cap_nxt_s     = cap_r;
    byte_sr_nxt_s = byte_sr_r;
    lfsr_en_s     = 1'b0;
    lfsr_seed_s   = 1'b0;
    byte_load_s   = 1'b0;
    done_s        = 1'b0;
    abort_s       = 1'b0;
    if (start_s) begin
      state_nxt_s   = PAYLOAD;
      lfsr_en_s     = 1'b1;
      lfsr_seed_s   = 1'b1;
      cnt_nxt_s     = CNT_ZERO;
      cap_nxt_s     = 7'h00;
      byte_sr_nxt_s = {6'h00, bit_in};
      abort_s       = (state_r == PAYLOAD) || ((state_r == CRC) && !crc_last_s);
      done_s        = crc_last_s;
    end else if (bit_valid) begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        PAYLOAD: begin
          lfsr_en_s     = 1'b1;
          cnt_nxt_s     = idx_s;
          byte_sr_nxt_s = {byte_sr_r[5:0], bit_in};
          byte_load_s   = (idx_s[2:0] == 3'd7);
          if (idx_s == LAST_PAY) begin
            state_nxt_s = CRC;
          end else begin
            state_nxt_s = PAYLOAD;
          end
        end
        CRC: begin
          if (crc_last_s) begin
            done_s      = 1'b1;
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = CRC;
            cnt_nxt_s   = idx_s;
            cap_nxt_s   = {cap_r[5:0], bit_in};
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Frame datapath registers and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= CNT_ZERO;
      cap_r      <= 7'h00;
      byte_sr_r  <= 7'h00;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      abort      <= 1'b0;
      crc_calc   <= 8'h00;
    end else begin
      cnt_r      <= cnt_nxt_s;
      cap_r      <= cap_nxt_s;
      byte_sr_r  <= byte_sr_nxt_s;
      byte_valid <= byte_load_s;
      frame_done <= done_s;
      crc_ok     <= done_s & crc_match_s;
      crc_err    <= done_s & ~crc_match_s;
      abort      <= abort_s;
      if (byte_load_s) begin
        byte_out <= {byte_sr_r, bit_in};
      end else begin
        byte_out <= byte_out;
      end
      // crc_s is still the frozen value of the finishing frame even when a
      // new frame seeds the register on this same edge.
      if (done_s) begin
        crc_calc <= crc_s;
      end else begin
        crc_calc <= crc_calc;
      end
    end
  end

`ifdef CRC8_CHK_ERRCNT_EN
  logic err_inc_s;
  assign err_inc_s = (done_s & ~crc_match_s) | abort_s;

  // Saturating link error counter, stepped with the crc_err/abort pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'h0000;
    end else if (err_inc_s && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end else begin
      err_cnt <= err_cnt;
    end
  end
`endif

endmodule
